// File: rtl/encoder4_2_pkg.sv
// Shared code constants and the decode result payload for the 4-to-2 encoder.
package encoder4_2_pkg;

  localparam int unsigned REQ_W  = 4;
  localparam int unsigned CODE_W = 2;

  localparam logic [CODE_W-1:0] CODE_Y3   = 2'b11;
  localparam logic [CODE_W-1:0] CODE_Y2   = 2'b10;
  localparam logic [CODE_W-1:0] CODE_Y1   = 2'b01;
  localparam logic [CODE_W-1:0] CODE_Y0   = 2'b00;
  localparam logic [CODE_W-1:0] CODE_NONE = 2'b00;

  // Decode result: index, legal-code flag, multi-hot flag.
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              valid;
    logic              err;
  } enc_result_t;

  localparam enc_result_t RESULT_IDLE = '{code: CODE_NONE, valid: 1'b0, err: 1'b0};

endpackage : encoder4_2_pkg

// File: rtl/encoder4_2_if.sv
// Request/code bundle between a requester and the encoder.
interface encoder4_2_if;

  logic en;
  logic Y3;
  logic Y2;
  logic Y1;
  logic Y0;
  logic A1;
  logic A0;
  logic valid;
  logic err;

  // Requester side: drives enable and request lines, observes the code.
  modport master (
    output en, Y3, Y2, Y1, Y0,
    input  A1, A0, valid, err
  );

  // Encoder side: samples requests, returns the registered code.
  modport slave (
    input  en, Y3, Y2, Y1, Y0,
    output A1, A0, valid, err
  );

endinterface : encoder4_2_if

// File: rtl/encoder4_2_comb.sv
// Purely combinational 4-to-2 decode: strict one-hot or priority (Y3 highest).
module encoder4_2_comb
  import encoder4_2_pkg::*;
#(
  parameter bit PRIORITY_EN = 1'b0
) (
  input  logic             en,
  input  logic [REQ_W-1:0] req,
  output enc_result_t      result_c
);

  // Next-code decode; disabled or illegal patterns fall back to the idle result.
  always_comb begin
    result_c = RESULT_IDLE;
    if (en) begin
      if (PRIORITY_EN) begin
        casez (req)
          4'b1???: result_c = '{code: CODE_Y3, valid: 1'b1, err: 1'b0};
          4'b01??: result_c = '{code: CODE_Y2, valid: 1'b1, err: 1'b0};
          4'b001?: result_c = '{code: CODE_Y1, valid: 1'b1, err: 1'b0};
          4'b0001: result_c = '{code: CODE_Y0, valid: 1'b1, err: 1'b0};
          default: result_c = RESULT_IDLE;
        endcase
      end else begin
        case (req)
          4'b1000: result_c = '{code: CODE_Y3, valid: 1'b1, err: 1'b0};
          4'b0100: result_c = '{code: CODE_Y2, valid: 1'b1, err: 1'b0};
          4'b0010: result_c = '{code: CODE_Y1, valid: 1'b1, err: 1'b0};
          4'b0001: result_c = '{code: CODE_Y0, valid: 1'b1, err: 1'b0};
          4'b0000: result_c = RESULT_IDLE;
          default: result_c = '{code: CODE_NONE, valid: 1'b0, err: 1'b1};
        endcase
      end
    end
  end

endmodule : encoder4_2_comb

// File: rtl/encoder4_2_behav_case.sv
// Registered 4-to-2 encoder with enable; one-cycle latency, synchronous reset.
module encoder4_2_behav_case
  import encoder4_2_pkg::*;
#(
  parameter bit PRIORITY_EN = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  encoder4_2_if.slave   bus
);

  logic [REQ_W-1:0] req;
  enc_result_t      next_c;
  enc_result_t      result_q;

  assign req = {bus.Y3, bus.Y2, bus.Y1, bus.Y0};

  encoder4_2_comb #(
    .PRIORITY_EN (PRIORITY_EN)
  ) u_comb (
    .en       (bus.en),
    .req      (req),
    .result_c (next_c)
  );

  // Output register; reset takes precedence over enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= RESULT_IDLE;
    end else begin
      result_q <= next_c;
    end
  end

  assign bus.A1    = result_q.code[1];
  assign bus.A0    = result_q.code[0];
  assign bus.valid = result_q.valid;
  assign bus.err   = result_q.err;

endmodule : encoder4_2_behav_case

// File: tb/tb_encoder4_2_behav_case.sv
// Checks strict and priority encoder instances against a counting reference model.
module tb_encoder4_2_behav_case;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  encoder4_2_if s_bus ();
  encoder4_2_if p_bus ();

  encoder4_2_behav_case #(.PRIORITY_EN(1'b0)) u_strict (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_bus)
  );

  encoder4_2_behav_case #(.PRIORITY_EN(1'b1)) u_prio (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (p_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: expected {A1,A0,valid,err} from bit counting and highest-set index.
  function automatic logic [3:0] model(input bit prio, input bit rst_v, input bit en_v,
                                       input logic [3:0] y);
    int ones;
    int hi;
    logic [1:0] a;
    logic v;
    logic e;
    ones = 0;
    hi   = 0;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) begin
        ones++;
        hi = i;
      end
    end
    a = 2'b00;
    v = 1'b0;
    e = 1'b0;
    if (rst_v && en_v) begin
      if (prio) begin
        v = (ones > 0);
        a = v ? 2'(hi) : 2'b00;
      end else if (ones == 1) begin
        v = 1'b1;
        a = 2'(hi);
      end else if (ones > 1) begin
        e = 1'b1;
      end
    end
    return {a, v, e};
  endfunction

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got A=%b valid=%b err=%b, expected A=%b valid=%b err=%b",
               tag, got[3:2], got[1], got[0], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // Apply one cycle of stimulus to both instances and check after the edge.
  task automatic step(input string tag, input bit r, input bit e, input logic [3:0] y);
    rst_n = r;
    s_bus.en = e;
    {s_bus.Y3, s_bus.Y2, s_bus.Y1, s_bus.Y0} = y;
    p_bus.en = e;
    {p_bus.Y3, p_bus.Y2, p_bus.Y1, p_bus.Y0} = y;
    @(posedge clk);
    #1;
    check({tag, "/strict"}, {s_bus.A1, s_bus.A0, s_bus.valid, s_bus.err}, model(1'b0, r, e, y));
    check({tag, "/prio"},   {p_bus.A1, p_bus.A0, p_bus.valid, p_bus.err}, model(1'b1, r, e, y));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    s_bus.en = 1'b0;
    p_bus.en = 1'b0;
    {s_bus.Y3, s_bus.Y2, s_bus.Y1, s_bus.Y0} = 4'b0000;
    {p_bus.Y3, p_bus.Y2, p_bus.Y1, p_bus.Y0} = 4'b0000;

    // Reset overrides enable, then release
    step("rst0", 1'b0, 1'b1, 4'b1000);
    step("rst1", 1'b0, 1'b1, 4'b1000);
    step("rel",  1'b1, 1'b1, 4'b1000);
    check("rel_a11", {s_bus.A1, s_bus.A0, s_bus.valid, s_bus.err}, 4'b1110);

    // Enable low, then each one-hot line
    step("en0",  1'b1, 1'b0, 4'b1000);
    check("en0_idle", {s_bus.A1, s_bus.A0, s_bus.valid, s_bus.err}, 4'b0000);
    step("y3", 1'b1, 1'b1, 4'b1000);
    step("y2", 1'b1, 1'b1, 4'b0100);
    check("y2_code", {s_bus.A1, s_bus.A0, s_bus.valid, s_bus.err}, 4'b1010);
    step("y1", 1'b1, 1'b1, 4'b0010);
    step("y0", 1'b1, 1'b1, 4'b0001);
    check("y0_alias", {s_bus.A1, s_bus.A0, s_bus.valid, s_bus.err}, 4'b0010);

    // Zero-hot and multi-hot
    step("zero", 1'b1, 1'b1, 4'b0000);
    step("multi", 1'b1, 1'b1, 4'b1010);
    check("multi_err", {s_bus.A1, s_bus.A0, s_bus.valid, s_bus.err}, 4'b0001);
    check("multi_prio", {p_bus.A1, p_bus.A0, p_bus.valid, p_bus.err}, 4'b1110);
    step("recover", 1'b1, 1'b1, 4'b0010);
    step("p0110", 1'b1, 1'b1, 4'b0110);
    check("p0110_code", {p_bus.A1, p_bus.A0, p_bus.valid, p_bus.err}, 4'b1010);
    step("p1111", 1'b1, 1'b1, 4'b1111);
    step("p0000", 1'b1, 1'b1, 4'b0000);

    // Mid-stream reset, then enable drops as reset releases
    step("pre", 1'b1, 1'b1, 4'b0100);
    step("midrst", 1'b0, 1'b1, 4'b0100);
    check("midrst_clr", {p_bus.A1, p_bus.A0, p_bus.valid, p_bus.err}, 4'b0000);
    step("relen0", 1'b1, 1'b0, 4'b0100);

    // Random traffic, occasional reset and enable drop
    for (int i = 0; i < 300; i++) begin
      step($sformatf("rnd%0d", i), ($urandom_range(0, 15) != 0), ($urandom_range(0, 7) != 0),
           4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_encoder4_2_behav_case
